// File: rtl/tube_arbiter_if.sv
// rtl/tube_arbiter_if.sv - request/grant and per-requester display data bundle for tube_arbiter
interface tube_arbiter_if;
  logic [2:0]  req;
  logic [31:0] digits0;
  logic [31:0] digits1;
  logic [31:0] digits2;
  logic [7:0]  dmask0;
  logic [7:0]  dmask1;
  logic [7:0]  dmask2;
  logic [2:0]  grant;

  modport master (
    output req, digits0, digits1, digits2, dmask0, dmask1, dmask2,
    input  grant
  );

  modport slave (
    input  req, digits0, digits1, digits2, dmask0, dmask1, dmask2,
    output grant
  );
endinterface

// File: rtl/tube_arbiter.sv
// rtl/tube_arbiter.sv - fixed-priority owner of the 8-digit tube with hold window and blank-on-switch
// Optional digit blinking is enabled by defining TUBE_ARB_BLINK_EN.
module tube_arbiter #(
  parameter logic [15:0] SCAN_DELAY = 16'd20000,
  parameter logic [31:0] MIN_HOLD   = 32'd10000000
`ifdef TUBE_ARB_BLINK_EN
  ,
  parameter logic [31:0] BLINK_HALF = 32'd50000000
`endif
) (
  input  logic              clk,
  input  logic              reset,
  tube_arbiter_if.slave     bus,
`ifdef TUBE_ARB_BLINK_EN
  input  logic [7:0]        blink,
`endif
  output logic [7:0]        tub_segments_1,
  output logic [7:0]        tub_segments_2,
  output logic [7:0]        tub_select
);

  typedef enum logic [1:0] {IDLE, GRANT, SWITCH} state_t;

  state_t      state;
  logic [1:0]  owner;
  logic [31:0] hold_cnt;
  logic [2:0]  grant_q;
  logic [15:0] scan_counter;
  logic [1:0]  scan_index;
  logic        tick;

  logic [31:0] sel_digits;
  logic [7:0]  sel_mask;
  logic [7:0]  eff_mask;
  logic [2:0]  left_pos;
  logic [2:0]  right_pos;
  logic [3:0]  left_nib;
  logic [3:0]  right_nib;
  logic [7:0]  frame_select;
  logic [7:0]  frame_seg1;
  logic [7:0]  frame_seg2;

  function automatic logic [1:0] top_req(input logic [2:0] r);
    if (r[2])      return 2'd2;
    else if (r[1]) return 2'd1;
    else           return 2'd0;
  endfunction

  function automatic logic [7:0] seg_lut(input logic [3:0] n);
    case (n)
      4'h0: return 8'b1111_1100;
      4'h1: return 8'b0110_0000;
      4'h2: return 8'b1101_1010;
      4'h3: return 8'b1111_0010;
      4'h4: return 8'b0110_0110;
      4'h5: return 8'b1011_0110;
      4'h6: return 8'b1011_1110;
      4'h7: return 8'b1110_0000;
      4'h8: return 8'b1111_1110;
      4'h9: return 8'b1110_0110;
      4'hA: return 8'b0000_0010;
      default: return 8'b0000_0000;
    endcase
  endfunction

  assign bus.grant = grant_q;
  assign tick      = (scan_counter == SCAN_DELAY - 16'd1);

`ifdef TUBE_ARB_BLINK_EN
  logic [31:0] phase_cnt;
  logic        blink_phase;

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_cnt   <= 32'd0;
      blink_phase <= 1'b0;
    end else if (phase_cnt == BLINK_HALF - 32'd1) begin
      phase_cnt   <= 32'd0;
      blink_phase <= ~blink_phase;
    end else begin
      phase_cnt   <= phase_cnt + 32'd1;
    end
  end
`endif

  // The frame source follows the registered grant, so a tick never shows an owner before grant is visible.
  always_comb begin
    sel_digits = bus.digits0;
    sel_mask   = bus.dmask0;
    if (grant_q[2]) begin
      sel_digits = bus.digits2;
      sel_mask   = bus.dmask2;
    end else if (grant_q[1]) begin
      sel_digits = bus.digits1;
      sel_mask   = bus.dmask1;
    end else if (!grant_q[0]) begin
      sel_mask   = 8'h00;
    end
`ifdef TUBE_ARB_BLINK_EN
    eff_mask = sel_mask & ~(blink_phase ? blink : 8'h00);
`else
    eff_mask = sel_mask;
`endif
    left_pos     = 3'd7 - {1'b0, scan_index};
    right_pos    = 3'd3 - {1'b0, scan_index};
    left_nib     = 4'(sel_digits >> {left_pos, 2'b00});
    right_nib    = 4'(sel_digits >> {right_pos, 2'b00});
    frame_select = (eff_mask[left_pos]  ? (8'b1 << left_pos)  : 8'h00)
                 | (eff_mask[right_pos] ? (8'b1 << right_pos) : 8'h00);
    frame_seg1   = eff_mask[left_pos]  ? seg_lut(left_nib)  : 8'h00;
    frame_seg2   = eff_mask[right_pos] ? seg_lut(right_nib) : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_counter   <= 16'd0;
      scan_index     <= 2'd0;
      tub_select     <= 8'h00;
      tub_segments_1 <= 8'h00;
      tub_segments_2 <= 8'h00;
    end else if (tick) begin
      scan_counter   <= 16'd0;
      scan_index     <= scan_index + 2'd1;
      tub_select     <= frame_select;
      tub_segments_1 <= frame_seg1;
      tub_segments_2 <= frame_seg2;
    end else begin
      scan_counter   <= scan_counter + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= 2'd0;
      hold_cnt <= 32'd0;
      grant_q  <= 3'b000;
    end else begin
      grant_q <= (state == GRANT) ? (3'b001 << owner) : 3'b000;
      case (state)
        IDLE: begin
          if (|bus.req) begin
            state    <= GRANT;
            owner    <= top_req(bus.req);
            hold_cnt <= 32'd0;
          end
        end
        GRANT: begin
          if (hold_cnt < MIN_HOLD) hold_cnt <= hold_cnt + 32'd1;
          if (!bus.req[owner])
            state <= SWITCH;
          else if (top_req(bus.req) > owner && hold_cnt >= MIN_HOLD)
            state <= SWITCH;
        end
        SWITCH: begin
          // Leave only on a tick where grant is already low, i.e. one that emitted a blank frame.
          if (tick && grant_q == 3'b000) begin
            if (|bus.req) begin
              state    <= GRANT;
              owner    <= top_req(bus.req);
              hold_cnt <= 32'd0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
